sync_sdp_ram: RTL and testbench
===============================

// Module: sync_sdp_ram
// PURPOSE
//   Single-clock simple-dual-port RAM: one write port, one read port. Successor to the
//   dual-clock buffer RAM for same-domain sector/data buffering. Adds per-lane write
//   enables, selectable read-during-write behaviour, an optional output register stage
//   with read-valid tracking, and a post-reset zero-fill sweep.
// PARAMETERS
//   DSIZE    8  data word width in bits; must be a multiple of LANE_W
//   ASIZE    4  address bits; DEPTH = 1<<ASIZE
//   LANE_W   8  write-enable lane width in bits; LANES = DSIZE/LANE_W
//   RDW_MODE 0  same-address read during write: 0 = old data, 1 = new (merged) data
//   OUT_REG  0  1 = extra output register, read latency 2 instead of 1
// PORTS
//   clk        in   1      clock
//   rst        in   1      synchronous reset, active high
//   wen        in   1      write request
//   waddr      in   ASIZE  write address
//   wdata      in   DSIZE  write data
//   wbe        in   LANES  lane write enables; bit i covers wdata[i*LANE_W +: LANE_W]
//   wfull      in   1      write inhibit (downstream full); blocks the write when high
//   ren        in   1      read request
//   raddr      in   ASIZE  read address
//   rdata      out  DSIZE  read data
//   rvalid     out  1      one-cycle pulse: rdata holds the data of an accepted read
//   init_done  out  1      high once zero-fill sweep is complete
// BEHAVIOUR
//   Reset (rst=1 on an edge): rdata=0, rvalid=0, init_done=0, pipeline stage cleared,
//     state=INIT, sweep counter=0. Memory contents are not touched by reset itself.
//   State INIT: each edge with rst=0 writes mem[cnt]=0 (all lanes) and increments cnt.
//     The edge writing DEPTH-1 sets init_done=1 and moves to RUN; the sweep takes exactly
//     DEPTH edges. wen and ren are ignored in INIT (no writes, no rvalid).
//   Reset mid-sweep restarts the sweep at address 0; init_done stays 0 until it finishes.
//   State RUN (terminal until rst): write accepted when wen && !wfull; only lanes with
//     wbe[i]=1 are updated. wbe=0 with wen=1 is a legal no-op.
//   Read accepted when ren=1 in RUN. OUT_REG=0: rdata/rvalid update at the same edge
//     (visible after edge N). OUT_REG=1: visible after edge N+1. Fully pipelined: one read
//     per cycle, back-to-back reads give back-to-back rvalid.
//   rdata holds its last value when no read completes; rvalid is 0 in those cycles.
//   Same-address read+write in one cycle: RDW_MODE=0 returns pre-write word; RDW_MODE=1
//     returns merged word (wbe lanes from wdata, other lanes from old word). A write
//     blocked by wfull is no write: old word returned in both modes.
//   Different-address read+write in one cycle: independent, no interaction.
//   Addresses are ASIZE bits; no out-of-range case exists.
// TESTING (DSIZE=32, ASIZE=4, LANE_W=8 unless stated)
//   Init: release rst, hold ren=1 raddr=0 -> init_done rises after exactly 16 edges, no
//     rvalid during sweep; then read all 16 addrs -> every word 0x00000000.
//   Lanes: write 0xAABBCCDD wbe=4'hF to addr 3, then 0x11223344 wbe=4'b0101 -> read
//     addr 3 returns 0xAA22CC44.
//   RDW: addr 5 holds 0x12345678; same cycle wen addr5 0xFFFFFFFF wbe=4'b0011 + ren addr5
//     -> RDW_MODE=0 returns 0x12345678, RDW_MODE=1 returns 0x1234FFFF; later read 0x1234FFFF.
//   wfull: wfull=1, write 0xDEADBEEF to addr 7 -> readback stays 0x00000000.
//   Reset mid-sweep: assert rst at sweep edge 9 for 1 cycle -> init_done rises 16 edges
//     after release; rdata=0, rvalid=0 right after reset.
//   Pipeline: OUT_REG=1, ren on 4 consecutive cycles addrs 0..3 -> rvalid high 4 cycles
//     starting one edge later than OUT_REG=0, data in order.

Source files
------------

// File: rtl/sync_sdp_ram.sv
// Single-clock simple-dual-port RAM with lane write enables, selectable read-during-write,
// optional output register and a zero-fill sweep after reset.
module sync_sdp_ram #(
    parameter int DSIZE    = 8,
    parameter int ASIZE    = 4,
    parameter int LANE_W   = 8,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wen,
    input  logic [ASIZE-1:0]          waddr,
    input  logic [DSIZE-1:0]          wdata,
    input  logic [DSIZE/LANE_W-1:0]   wbe,
    input  logic                      wfull,
    input  logic                      ren,
    input  logic [ASIZE-1:0]          raddr,
    output logic [DSIZE-1:0]          rdata,
    output logic                      rvalid,
    output logic                      init_done
);
    localparam int DEPTH = 1 << ASIZE;
    localparam int LANES = DSIZE / LANE_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    logic [DSIZE-1:0] mem [DEPTH];

    state_t           state_q, state_d;
    logic [ASIZE-1:0] cnt_q, cnt_d;
    logic             init_done_q, init_done_d;
    logic [DSIZE-1:0] rd1_data_q, rd1_data_d;
    logic             rd1_vld_q, rd1_vld_d;
    logic [DSIZE-1:0] rd2_data_q, rd2_data_d;
    logic             rd2_vld_q, rd2_vld_d;

    logic             run, wr_acc, rd_acc;
    logic             wr_en;
    logic [ASIZE-1:0] wr_addr;
    logic [DSIZE-1:0] wr_data, old_word, wold_word, merged_word, rd_word;

    // Lane merge of the incoming write with the word currently at waddr.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign merged_word[i*LANE_W +: LANE_W] = wbe[i] ? wdata[i*LANE_W +: LANE_W]
                                                        : wold_word[i*LANE_W +: LANE_W];
    end

    always_comb begin
        run       = (state_q == ST_RUN);
        wr_acc    = run && wen && !wfull;
        rd_acc    = run && ren;
        old_word  = mem[raddr];
        wold_word = mem[waddr];
        rd_word   = (RDW_MODE != 0 && wr_acc && waddr == raddr) ? merged_word : old_word;

        // The sweep owns the write port until it finishes.
        wr_en   = run ? wr_acc : 1'b1;
        wr_addr = run ? waddr : cnt_q;
        wr_data = run ? merged_word : '0;

        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        if (!run) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end

        rd1_vld_d  = rd_acc;
        rd1_data_d = rd_acc ? rd_word : rd1_data_q;
        rd2_vld_d  = rd1_vld_q;
        rd2_data_d = rd1_vld_q ? rd1_data_q : rd2_data_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            rd1_data_q  <= '0;
            rd1_vld_q   <= 1'b0;
            rd2_data_q  <= '0;
            rd2_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rd1_data_q  <= rd1_data_d;
            rd1_vld_q   <= rd1_vld_d;
            rd2_data_q  <= rd2_data_d;
            rd2_vld_q   <= rd2_vld_d;
        end
    end

    assign rdata     = (OUT_REG != 0) ? rd2_data_q : rd1_data_q;
    assign rvalid    = (OUT_REG != 0) ? rd2_vld_q  : rd1_vld_q;
    assign init_done = init_done_q;
endmodule

// File: tb/tb_sync_sdp_ram.sv
// Drives three configurations (old-data, new-data, output-registered) with one stimulus
// stream and scoreboards each read against a bench-side memory model.
module tb_sync_sdp_ram;
    logic        clk = 1'b0;
    logic        rst, wen, wfull, ren;
    logic [3:0]  waddr, raddr, wbe;
    logic [31:0] wdata;
    logic [2:0][31:0] rdata_w, last;
    logic [2:0]  rvalid_w, done_w;

    typedef struct { logic [31:0] d0; logic [31:0] d1; int due; } exp_t;
    exp_t qa[$];
    exp_t qp[$];
    exp_t ea, ep, e;
    logic ev_a, ev_p;

    logic [31:0] mem_m [16];
    logic        m_run;
    int          m_cnt;
    int          cyc = 0;
    int          ntest = 0;
    int          nfail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sync_sdp_ram #(.DSIZE(32), .ASIZE(4), .LANE_W(8), .RDW_MODE(0), .OUT_REG(0)) u_old (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .wfull(wfull), .ren(ren), .raddr(raddr), .rdata(rdata_w[0]), .rvalid(rvalid_w[0]),
        .init_done(done_w[0]));
    sync_sdp_ram #(.DSIZE(32), .ASIZE(4), .LANE_W(8), .RDW_MODE(1), .OUT_REG(0)) u_new (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .wfull(wfull), .ren(ren), .raddr(raddr), .rdata(rdata_w[1]), .rvalid(rvalid_w[1]),
        .init_done(done_w[1]));
    sync_sdp_ram #(.DSIZE(32), .ASIZE(4), .LANE_W(8), .RDW_MODE(0), .OUT_REG(1)) u_pipe (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .wfull(wfull), .ren(ren), .raddr(raddr), .rdata(rdata_w[2]), .rvalid(rvalid_w[2]),
        .init_done(done_w[2]));

    task automatic check_one(input int k, input logic ev, input logic [31:0] d);
        ntest++;
        assert (rvalid_w[k] === ev) else begin
            nfail++;
            $error("FAIL rvalid dut%0d cyc=%0d got=%b exp=%b", k, cyc, rvalid_w[k], ev);
        end
        ntest++;
        if (ev) begin
            assert (rdata_w[k] === d) else begin
                nfail++;
                $error("FAIL rdata dut%0d cyc=%0d got=%h exp=%h", k, cyc, rdata_w[k], d);
            end
            last[k] = d;
        end else begin
            assert (rdata_w[k] === last[k]) else begin
                nfail++;
                $error("FAIL rdata_hold dut%0d cyc=%0d got=%h exp=%h", k, cyc, rdata_w[k], last[k]);
            end
        end
    endtask

    // Output monitor: mid-cycle, away from the active edge.
    always @(negedge clk) begin
        while (qa.size() > 0 && qa[0].due < cyc) qa.delete(0);
        while (qp.size() > 0 && qp[0].due < cyc) qp.delete(0);
        ev_a = (qa.size() > 0) && (qa[0].due == cyc);
        ev_p = (qp.size() > 0) && (qp[0].due == cyc);
        ea = '{32'h0, 32'h0, 0};
        ep = '{32'h0, 32'h0, 0};
        if (ev_a) ea = qa.pop_front();
        if (ev_p) ep = qp.pop_front();
        check_one(0, ev_a, ea.d0);
        check_one(1, ev_a, ea.d1);
        check_one(2, ev_p, ep.d0);
    end

    // Advance one edge: update the model with the driven inputs, then check init_done.
    task automatic tick();
        logic [31:0] old, merged;
        logic        wr_ok, was_rst;
        was_rst = rst;
        if (rst) begin
            m_run = 1'b0;
            m_cnt = 0;
        end else if (!m_run) begin
            mem_m[m_cnt] = 32'h0;
            if (m_cnt == 15) m_run = 1'b1;
            m_cnt++;
        end else begin
            old    = mem_m[raddr];
            merged = mem_m[waddr];
            for (int i = 0; i < 4; i++)
                if (wbe[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
            wr_ok = wen && !wfull;
            if (ren) begin
                e.d0  = old;
                e.d1  = (wr_ok && waddr == raddr) ? merged : old;
                e.due = cyc + 1;
                qa.push_back(e);
                e.d1  = 32'h0;
                e.due = cyc + 2;
                qp.push_back(e);
            end
            if (wr_ok) mem_m[waddr] = merged;
        end
        @(posedge clk);
        #1;
        if (was_rst) begin
            last = '0;
            qa.delete();
            qp.delete();
        end
        ntest++;
        assert (done_w === {3{m_run}}) else begin
            nfail++;
            $error("FAIL init_done cyc=%0d got=%b exp=%b", cyc, done_w, {3{m_run}});
        end
    endtask

    task automatic idle(input int n);
        wen = 1'b0; ren = 1'b0; wfull = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wen = 1'b1; ren = 1'b0; waddr = a; wdata = d; wbe = be;
        tick();
        wen = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        wen = 1'b0; ren = 1'b1; raddr = a;
        tick();
        ren = 1'b0;
    endtask

    initial begin
        last = '0; m_run = 1'b0; m_cnt = 0;
        rst = 1'b1; wen = 1'b0; wfull = 1'b0; ren = 1'b0;
        waddr = '0; raddr = '0; wbe = '0; wdata = '0;
        tick(); tick();
        ntest++;
        assert (rdata_w === '0 && rvalid_w === '0) else begin
            nfail++; $error("FAIL reset_out got=%h/%b exp=0/0", rdata_w, rvalid_w);
        end

        // Sweep with a read held pending: no rvalid, init_done after 16 edges.
        rst = 1'b0; ren = 1'b1; raddr = 4'd0;
        for (int i = 0; i < 16; i++) tick();
        for (int a = 0; a < 16; a++) begin raddr = 4'(a); tick(); end
        idle(3);

        // Lane enables
        wr(4'd3, 32'hAABBCCDD, 4'hF);
        wr(4'd3, 32'h11223344, 4'b0101);
        rd(4'd3);
        wr(4'd3, 32'h55555555, 4'h0);
        rd(4'd3);
        idle(3);

        // Same-address read during write, then readback
        wr(4'd5, 32'h12345678, 4'hF);
        wen = 1'b1; waddr = 4'd5; wdata = 32'hFFFFFFFF; wbe = 4'b0011;
        ren = 1'b1; raddr = 4'd5;
        tick();
        rd(4'd5);
        idle(3);

        // Blocked write, with a same-address read in the same cycle
        wfull = 1'b1; wen = 1'b1; waddr = 4'd7; wdata = 32'hDEADBEEF; wbe = 4'hF;
        ren = 1'b1; raddr = 4'd7;
        tick();
        wfull = 1'b0;
        rd(4'd7);

        // Different-address read and write together
        wen = 1'b1; waddr = 4'd8; wdata = 32'hCAFEF00D; wbe = 4'hF;
        ren = 1'b1; raddr = 4'd3;
        tick();
        rd(4'd8);
        idle(3);

        // Back-to-back reads of distinct words
        for (int a = 0; a < 4; a++) wr(4'(a), 32'hA0000000 + 32'(a), 4'hF);
        ren = 1'b1;
        for (int a = 0; a < 4; a++) begin raddr = 4'(a); tick(); end
        idle(3);

        // Mixed traffic over a narrow address range to provoke collisions
        for (int i = 0; i < 60; i++) begin
            wen   = 1'($urandom_range(0, 1));
            ren   = 1'($urandom_range(0, 1));
            wfull = ($urandom_range(0, 3) == 0);
            waddr = 4'($urandom_range(0, 3));
            raddr = 4'($urandom_range(0, 3));
            wbe   = 4'($urandom);
            wdata = $urandom;
            tick();
        end
        idle(3);

        // Reset mid-sweep
        rst = 1'b1; tick();
        rst = 1'b0; ren = 1'b1; raddr = 4'd0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1; tick();
        ntest++;
        assert (rdata_w === '0 && rvalid_w === '0) else begin
            nfail++; $error("FAIL midsweep_reset got=%h/%b exp=0/0", rdata_w, rvalid_w);
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        ren = 1'b1;
        for (int a = 0; a < 4; a++) begin raddr = 4'(a); tick(); end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
